sha_round_sequencer: RTL and testbench
======================================

# sha_round_sequencer

Drives the shared `round`/`Kt` bus of two chained `sha_unit` instances and sweeps a nonce range through them. The first unit hashes the header tail with the job midstate; the second hashes that digest. The two units run as a two-stage pipeline, one nonce per 64-cycle epoch. The sequencer also checks each final digest against a difficulty mask and reports the first winning nonce.

## Interface
- `ZERO_BITS`, 32: required count of zero low-order bits of the final digest. Must be a multiple of 8, range 8..64.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a job. Sampled only in IDLE.
- `halt`  in  1  abort the job. Sampled only while busy.
- `nonce_start`  in  32  first nonce. Captured on the accepting edge of `start`.
- `nonce_end`  in  32  last nonce, inclusive. Captured on the accepting edge of `start`.
- `hash_in`  in  256  second unit's digest (`H_u1`).
- `round`  out  6  round index to both units.
- `Kt`  out  32  round constant to both units.
- `nonce`  out  32  nonce the first unit is hashing in this epoch.
- `capture_h`  out  1  tells external logic to latch `H_u0[223:0]` on this edge.
- `busy`  out  1  job in progress.
- `found`  out  1  one-cycle pulse: a match was found.
- `found_nonce`  out  32  winning nonce. Held until the next found.
- `done`  out  1  one-cycle pulse: the job has ended.

## Operation
- States:
  - IDLE: `round` held at 0.
  - RUN: `round` increments each cycle and wraps 63→0. Each wrap starts a new epoch.
- Round constant:
  - `Kt` is a register loaded each edge with K[`round`] from the internal 64-entry SHA-256 K ROM.
  - The result is `Kt` = K[(`round`+63) mod 64] at all times. This is the one-round lag the `sha_unit` W/K pipeline expects.
- Epoch k of a job of N nonces (N = `nonce_end` − `nonce_start` + 1, mod 2^32, so 1..2^32):
  - For k < N: `nonce` = `nonce_start`+k (mod 2^32), held for the whole epoch.
  - For k ≥ N (drain): `nonce` holds its last value. The first unit's output is ignored.
- Pipeline valid bits:
  - v1 = epoch k−1 carried a nonce.
  - v2 = epoch k−2 carried a nonce.
  - Nonce copies d1 and d2 shift on each wrap.
- `capture_h` is high in the round-0 cycle of any epoch with v1=1.
- Check:
  - Performed on the edge ending the round-0 cycle of an epoch with v2=1.
  - Match when `hash_in`[ZERO_BITS−1:0] == 0, i.e. the byte-reversed Bitcoin digest has leading zeros.
  - On match: `found` pulses, `found_nonce` ← d2, `done` pulses, and the state returns to IDLE. The job stops on the first match.
- Last nonce checked with no match: `done` pulses without `found`; the state returns to IDLE.
- Halt:
  - Has priority over the check.
  - The next edge returns to IDLE with `round`←0.
  - `done` pulses; `found` stays 0.
  - `capture_h` is forced low.
- Ignored inputs: `start` while busy, and `halt` in IDLE.
- Reset values:
  - `round` 0, `Kt` 32'hc67178f2 (K[63]).
  - `nonce` 0, `found_nonce` 0.
  - `capture_h`, `busy`, `found`, `done` all 0.
- An asynchronous reset mid-job forces the reset values immediately; no `done` is issued.

## Timing
- Cycle c means the c-th cycle after the edge that accepted `start`.
- Epoch k, round r occupies cycle 1+64k+r.
- Nonce k is checked at the end of cycle 1+64(k+2). `found`/`done` are high in cycle 2+64(k+2).
- No match: `done` is high in cycle 2+64(N+1). For N=1 that is cycle 130.
- `busy`:
  - High from cycle 1 through the check cycle.
  - Low in the cycle where `done` is high.
  - A new `start` is accepted in that same cycle.
- `Kt` examples:
  - K[0]=32'h428a2f98 when `round`=1.
  - K[63] when `round`=0 in every epoch.
- `found`, `done`, and `found_nonce` are registered. All other outputs are registered as well.

## Test plan
- **Reset:** assert `reset_n`=0 mid-epoch → all outputs take their reset values within the same cycle; `Kt`=c67178f2.
- **Single nonce, no match:** `nonce_start`=`nonce_end`=0, ZERO_BITS=8; bench feeds `hash_in` = 766f7950…88c2565c at check time → `capture_h` high only in cycle 65; `Kt`=428a2f98 in cycles 2 and 66; `done` in cycle 130; `found`=0.
- **Match in a range:** range 5..9; `hash_in` low byte 00 only at the check of nonce 7 → `found` and `done` both high in cycle 258; `found_nonce`=7; `busy` low in cycle 258.
- **Nonce wrap:** range FFFFFFFE..00000001 → `nonce` sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001 at cycles 1/65/129/193; `done` in cycle 322.
- **Halt:** range 0..99; `halt` at round 30 of epoch 1 → next cycle has `round`=0, `busy`=0, `done`=1, `found`=0. A `start` during the job is ignored.
- **Halt vs. match:** `halt` coincides with a matching check cycle → `found` stays 0, `done`=1, `found_nonce` unchanged.

Source files
------------

// File: rtl/sha_round_sequencer.sv
// rtl/sha_round_sequencer.sv - round/Kt driver and nonce sweeper for two chained sha_unit stages
// Nonces enter the first unit one per 64-round epoch; the second unit's digest is checked two epochs later.
module sha_round_sequencer #(
  parameter int ZERO_BITS = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         halt,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] hash_in,
  output logic [5:0]   round,
  output logic [31:0]  Kt,
  output logic [31:0]  nonce,
  output logic         capture_h,
  output logic         busy,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic         done
);

  localparam logic [2047:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [5:0]  round_n, kt_idx;
  logic [31:0] nonce_n, rem, rem_n, d1, d1_n, d2, d2_n, found_nonce_n;
  logic        cur_v, cur_v_n, v1, v1_n, v2, v2_n;
  logic        found_n, done_n, capture_n;
  logic        match, check;
  logic        unused_hash;

  assign match       = (hash_in[ZERO_BITS-1:0] == '0);
  assign check       = (round == 6'd0) && v2;
  assign unused_hash = ^hash_in[255:ZERO_BITS];
  // Kt lags round by one: it always holds K[round-1], so K[63] in IDLE and at every round 0.
  assign kt_idx      = round_n - 6'd1;

  always_comb begin
    state_n       = state;
    round_n       = round;
    nonce_n       = nonce;
    rem_n         = rem;
    d1_n          = d1;
    d2_n          = d2;
    cur_v_n       = cur_v;
    v1_n          = v1;
    v2_n          = v2;
    found_n       = 1'b0;
    done_n        = 1'b0;
    found_nonce_n = found_nonce;
    case (state)
      IDLE: begin
        round_n = 6'd0;
        if (start) begin
          state_n = RUN;
          nonce_n = nonce_start;
          rem_n   = nonce_end - nonce_start;
          cur_v_n = 1'b1;
          v1_n    = 1'b0;
          v2_n    = 1'b0;
        end
      end
      RUN: begin
        if (halt || (check && match) || (check && !v1 && !cur_v)) begin
          state_n = IDLE;
          round_n = 6'd0;
          done_n  = 1'b1;
          cur_v_n = 1'b0;
          v1_n    = 1'b0;
          v2_n    = 1'b0;
          if (!halt && check && match) begin
            found_n       = 1'b1;
            found_nonce_n = d2;
          end
        end else begin
          round_n = round + 6'd1;
          if (round == 6'd63) begin
            v1_n = cur_v;
            v2_n = v1;
            d1_n = nonce;
            d2_n = d1;
            // Once the range is exhausted the nonce freezes and the first unit drains.
            if (cur_v) begin
              if (rem == 32'd0) begin
                cur_v_n = 1'b0;
              end else begin
                nonce_n = nonce + 32'd1;
                rem_n   = rem - 32'd1;
              end
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
    capture_n = (state_n == RUN) && (round_n == 6'd0) && v1_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      round       <= 6'd0;
      Kt          <= 32'hc67178f2;
      nonce       <= 32'd0;
      rem         <= 32'd0;
      d1          <= 32'd0;
      d2          <= 32'd0;
      cur_v       <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      capture_h   <= 1'b0;
      busy        <= 1'b0;
      found       <= 1'b0;
      found_nonce <= 32'd0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      round       <= round_n;
      Kt          <= K_ROM[{~kt_idx, 5'd0} +: 32];
      nonce       <= nonce_n;
      rem         <= rem_n;
      d1          <= d1_n;
      d2          <= d2_n;
      cur_v       <= cur_v_n;
      v1          <= v1_n;
      v2          <= v2_n;
      capture_h   <= capture_n;
      busy        <= (state_n == RUN);
      found       <= found_n;
      found_nonce <= found_nonce_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_sha_round_sequencer.sv
// tb/tb_sha_round_sequencer.sv - directed self-checking bench for sha_round_sequencer
module tb_sha_round_sequencer;

  localparam logic [255:0] H_MISS = 256'h766f7950_0badf00d_12345678_9abcdef0_0f1e2d3c_4b5a6978_deadbeef_88c2565c;
  localparam logic [31:0]  K0     = 32'h428a2f98;
  localparam logic [31:0]  K63    = 32'hc67178f2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         halt;
  logic [31:0]  nonce_start;
  logic [31:0]  nonce_end;
  logic [255:0] hash_in;
  logic [5:0]   round;
  logic [31:0]  Kt;
  logic [31:0]  nonce;
  logic         capture_h;
  logic         busy;
  logic         found;
  logic [31:0]  found_nonce;
  logic         done;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  sha_round_sequencer #(.ZERO_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt(halt),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .hash_in(hash_in),
    .round(round), .Kt(Kt), .nonce(nonce), .capture_h(capture_h), .busy(busy),
    .found(found), .found_nonce(found_nonce), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_job(input logic [31:0] s, input logic [31:0] e);
    nonce_start = s;
    nonce_end   = e;
    start       = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    cyc = 1;
  endtask

  task automatic test_reset;
    total++; if ({round, Kt, nonce, found_nonce} !== {6'd0, K63, 32'd0, 32'd0}) begin
      $display("FAIL reset_values round=%0d Kt=%h nonce=%h fn=%h expected 0/%h/0/0", round, Kt, nonce, found_nonce, K63);
    end else passed++;
    total++; if ({capture_h, busy, found, done} !== 4'b0000) begin
      $display("FAIL reset_flags got %b expected 0000", {capture_h, busy, found, done});
    end else passed++;
  endtask

  task automatic test_single_nonce;
    int cap_bad = 0, done_early = 0;
    logic [31:0] kt2 = 0, kt66 = 0;
    hash_in = H_MISS;
    start_job(32'd0, 32'd0);
    total++; if ({round, Kt, busy} !== {6'd0, K63, 1'b1}) begin
      $display("FAIL single_cycle1 round=%0d Kt=%h busy=%b expected 0/%h/1", round, Kt, busy, K63);
    end else passed++;
    while (cyc < 130) begin
      if (capture_h !== (cyc == 65)) cap_bad++;
      if (done !== 1'b0) done_early++;
      if (cyc == 2)  kt2  = Kt;
      if (cyc == 66) kt66 = Kt;
      step();
    end
    total++; if (cap_bad !== 0) $display("FAIL single_capture_h bad_cycles=%0d expected 0", cap_bad); else passed++;
    total++; if (done_early !== 0) $display("FAIL single_done_early count=%0d expected 0", done_early); else passed++;
    total++; if ({kt2, kt66} !== {K0, K0}) $display("FAIL single_kt c2=%h c66=%h expected %h", kt2, kt66, K0); else passed++;
    total++; if ({done, found, busy} !== 3'b100) begin
      $display("FAIL single_done_c130 done/found/busy=%b expected 100", {done, found, busy});
    end else passed++;
  endtask

  task automatic test_match_range;
    int early = 0;
    logic [31:0] n129 = 0;
    start_job(32'd5, 32'd9);
    while (cyc < 258) begin
      hash_in = (cyc == 257) ? {H_MISS[255:8], 8'h00} : H_MISS;
      if (found !== 1'b0 || done !== 1'b0) early++;
      if (cyc == 129) n129 = nonce;
      step();
    end
    hash_in = H_MISS;
    total++; if (early !== 0) $display("FAIL match_early count=%0d expected 0", early); else passed++;
    total++; if (n129 !== 32'd7) $display("FAIL match_nonce_c129 got %h expected 7", n129); else passed++;
    total++; if ({found, done, busy} !== 3'b110) begin
      $display("FAIL match_c258 found/done/busy=%b expected 110", {found, done, busy});
    end else passed++;
    total++; if (found_nonce !== 32'd7) $display("FAIL match_found_nonce got %h expected 7", found_nonce); else passed++;
    step();
    total++; if ({found, done} !== 2'b00) $display("FAIL match_pulse_width found/done=%b expected 00", {found, done}); else passed++;
  endtask

  task automatic test_nonce_wrap;
    logic [31:0] seen [4];
    logic [5:0] r100 = 0;
    int early = 0;
    start_job(32'hFFFFFFFE, 32'h00000001);
    while (cyc < 322) begin
      if (cyc == 1)   seen[0] = nonce;
      if (cyc == 65)  seen[1] = nonce;
      if (cyc == 129) seen[2] = nonce;
      if (cyc == 193) seen[3] = nonce;
      if (cyc == 100) r100 = round;
      if (done !== 1'b0) early++;
      step();
    end
    total++; if ({seen[0], seen[1], seen[2], seen[3]} !== {32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1}) begin
      $display("FAIL wrap_sequence got %h %h %h %h expected fffffffe ffffffff 0 1", seen[0], seen[1], seen[2], seen[3]);
    end else passed++;
    total++; if (r100 !== 6'd35) $display("FAIL wrap_round_c100 got %0d expected 35", r100); else passed++;
    total++; if ({done, early != 0} !== 2'b10) $display("FAIL wrap_done_c322 done=%b early=%0d expected 1/0", done, early); else passed++;
  endtask

  task automatic test_back_to_back;
    start_job(32'd2, 32'd2);
    while (cyc < 130) step();
    total++; if (done !== 1'b1) $display("FAIL b2b_first_done got %b expected 1", done); else passed++;
    nonce_start = 32'h10;
    nonce_end   = 32'h10;
    start       = 1'b1;
    step();
    start = 1'b0;
    total++; if ({busy, nonce, round} !== {1'b1, 32'h10, 6'd0}) begin
      $display("FAIL b2b_restart busy=%b nonce=%h round=%0d expected 1/10/0", busy, nonce, round);
    end else passed++;
    halt = 1'b1;
    step();
    halt = 1'b0;
    step();
  endtask

  task automatic test_halt;
    logic [31:0] n65 = 0;
    start_job(32'd0, 32'd99);
    while (cyc < 95) begin
      if (cyc == 10) begin
        nonce_start = 32'd50;
        start       = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (cyc == 65) n65 = nonce;
      step();
    end
    total++; if (n65 !== 32'd1) $display("FAIL halt_start_ignored nonce=%h expected 1", n65); else passed++;
    total++; if (round !== 6'd30) $display("FAIL halt_round30 got %0d expected 30", round); else passed++;
    halt = 1'b1;
    step();
    halt = 1'b0;
    total++; if ({round, busy, done, found, capture_h} !== {6'd0, 4'b0100}) begin
      $display("FAIL halt_response round=%0d busy/done/found/cap=%b expected 0/0100", round, {busy, done, found, capture_h});
    end else passed++;
    total++; if (Kt !== K63) $display("FAIL halt_kt got %h expected %h", Kt, K63); else passed++;
    halt = 1'b1;
    step();
    halt = 1'b0;
    step();
    total++; if ({busy, done} !== 2'b00) $display("FAIL halt_in_idle busy/done=%b expected 00", {busy, done}); else passed++;
  endtask

  task automatic test_halt_vs_match;
    start_job(32'd0, 32'd99);
    while (cyc < 129) step();
    hash_in = {H_MISS[255:8], 8'h00};
    halt    = 1'b1;
    step();
    halt    = 1'b0;
    hash_in = H_MISS;
    total++; if ({found, done, busy} !== 3'b010) begin
      $display("FAIL halt_match found/done/busy=%b expected 010", {found, done, busy});
    end else passed++;
    total++; if (found_nonce !== 32'd7) $display("FAIL halt_match_found_nonce got %h expected 7", found_nonce); else passed++;
  endtask

  task automatic test_async_reset;
    start_job(32'd3, 32'd99);
    while (cyc < 66) step();
    #2 reset_n = 1'b0;
    #1;
    total++; if ({round, Kt, nonce, found_nonce} !== {6'd0, K63, 32'd0, 32'd0}) begin
      $display("FAIL async_reset_values round=%0d Kt=%h nonce=%h fn=%h expected 0/%h/0/0", round, Kt, nonce, found_nonce, K63);
    end else passed++;
    total++; if ({capture_h, busy, found, done} !== 4'b0000) begin
      $display("FAIL async_reset_flags got %b expected 0000", {capture_h, busy, found, done});
    end else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    total++; if ({busy, done} !== 2'b00) $display("FAIL async_reset_no_done busy/done=%b expected 00", {busy, done}); else passed++;
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    halt        = 1'b0;
    nonce_start = 32'd0;
    nonce_end   = 32'd0;
    hash_in     = H_MISS;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_single_nonce();
    step();
    test_match_range();
    test_nonce_wrap();
    step();
    test_back_to_back();
    test_halt();
    test_halt_vs_match();
    step();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
